// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: parses SYNC/CMD/LEN/payload/CHK frames
// delimited by chip select and buffers the payload for readback.
module spi_frame_ctrl #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         sel_in,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid_in,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr_in,
  output logic [7:0]                   rd_data_out,
  output logic [7:0]                   cmd_out,
  output logic [$clog2(MAX_LEN+1)-1:0] len_out,
  output logic                         frame_valid_out,
  output logic                         frame_err_out,
  output logic [1:0]                   err_code_out,
  output logic                         busy_out
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN+1);

  localparam logic [1:0] E_TRUNC = 2'd0;
  localparam logic [1:0] E_SYNC  = 2'd1;
  localparam logic [1:0] E_LEN   = 2'd2;
  localparam logic [1:0] E_CHK   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            sel_prev;
  logic            armed_q;
  logic            armed_d;
  logic [LW-1:0]   idx_q;
  logic [LW-1:0]   len_tmp;
  logic [7:0]      cmd_tmp;
  logic [7:0]      csum_q;
  logic [7:0]      mem_q [MAX_LEN];

  logic            fall;
  logic            rise;
  logic            start;
  logic            in_frame;
  logic            len_bad;
  logic            len_zero;
  logic            chk_ok;
  logic            pay_last;
  logic            done_step;
  logic            abort;
  logic            trunc;

  logic            ev_valid;
  logic            ev_err;
  logic [1:0]      ev_code;

  assign fall  = sel_prev & ~sel_in;
  assign rise  = ~sel_prev & sel_in;
  assign start = byte_valid_in & (armed_q | fall);

  assign in_frame = (state_q == S_CMD)
                  | (state_q == S_LEN)
                  | (state_q == S_PAYLOAD)
                  | (state_q == S_CHK);

  assign len_bad  = int'({24'd0, byte_in}) > MAX_LEN;
  assign len_zero = byte_in == 8'd0;
  assign chk_ok   = byte_in == csum_q;
  assign pay_last = (idx_q + LW'(1)) == len_tmp;

  // A byte that ends the frame wins over a coincident rising edge.
  assign done_step = byte_valid_in
                   & (((state_q == S_LEN) & len_bad)
                      | (state_q == S_CHK));

  assign abort = fall & (state_q != S_IDLE);
  assign trunc = rise & in_frame & ~done_step;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      sel_prev <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_prev <= sel_in;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = (byte_in == SYNC_BYTE)
                  ? S_CMD : S_DRAIN;
      end
      S_CMD: begin
        if (byte_valid_in)
          state_d = S_LEN;
      end
      S_LEN: begin
        if (byte_valid_in) begin
          if (len_bad)
            state_d = S_DRAIN;
          else if (len_zero)
            state_d = S_CHK;
          else
            state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (byte_valid_in && pay_last)
          state_d = S_CHK;
      end
      S_CHK: begin
        if (byte_valid_in)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (sel_in)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (trunc || abort)
      state_d = S_IDLE;
    // Arming survives only in IDLE, until the window closes.
    armed_d = (state_d == S_IDLE)
            & (fall
               | (armed_q & ~rise
                  & (state_q == S_IDLE)));
  end

  always_comb begin
    ev_valid = 1'b0;
    ev_err   = 1'b0;
    ev_code  = E_TRUNC;
    if (!abort) begin
      if (trunc) begin
        ev_err  = 1'b1;
        ev_code = E_TRUNC;
      end else if (byte_valid_in) begin
        unique case (state_q)
          S_IDLE: begin
            if (start && byte_in != SYNC_BYTE) begin
              ev_err  = 1'b1;
              ev_code = E_SYNC;
            end
          end
          S_LEN: begin
            if (len_bad) begin
              ev_err  = 1'b1;
              ev_code = E_LEN;
            end
          end
          S_CHK: begin
            if (chk_ok) begin
              ev_valid = 1'b1;
            end else begin
              ev_err  = 1'b1;
              ev_code = E_CHK;
            end
          end
          default: ;
        endcase
      end
    end
    busy_out = state_q != S_IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q           <= '0;
      len_tmp         <= '0;
      cmd_tmp         <= 8'd0;
      csum_q          <= 8'd0;
      cmd_out         <= 8'd0;
      len_out         <= '0;
      frame_valid_out <= 1'b0;
      frame_err_out   <= 1'b0;
      err_code_out    <= E_TRUNC;
    end else begin
      frame_valid_out <= ev_valid;
      frame_err_out   <= ev_err;
      if (ev_err)
        err_code_out <= ev_code;
      if (ev_valid) begin
        cmd_out <= cmd_tmp;
        len_out <= len_tmp;
      end
      if (byte_valid_in) begin
        unique case (state_q)
          S_CMD: begin
            cmd_tmp <= byte_in;
            csum_q  <= byte_in;
            idx_q   <= '0;
          end
          S_LEN: begin
            csum_q <= csum_q + byte_in;
            if (!len_bad)
              len_tmp <= LW'(byte_in);
          end
          S_PAYLOAD: begin
            csum_q <= csum_q + byte_in;
            idx_q  <= idx_q + LW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (byte_valid_in && state_q == S_PAYLOAD)
      mem_q[idx_q[AW-1:0]] <= byte_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      rd_data_out <= 8'd0;
    else
      rd_data_out <= mem_q[rd_addr_in];
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: table of frames with a pulse scoreboard,
// plus reset and idle-byte sequences.
module tb_spi_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN+1);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          sel_in;
  logic [7:0]    byte_in;
  logic          byte_valid_in;
  logic [AW-1:0] rd_addr_in;
  logic [7:0]    rd_data_out;
  logic [7:0]    cmd_out;
  logic [LW-1:0] len_out;
  logic          frame_valid_out;
  logic          frame_err_out;
  logic [1:0]    err_code_out;
  logic          busy_out;

  always #5 clk_in = ~clk_in;

  spi_frame_ctrl #(
    .MAX_LEN(MAX_LEN),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .sel_in(sel_in),
    .byte_in(byte_in),
    .byte_valid_in(byte_valid_in),
    .rd_addr_in(rd_addr_in),
    .rd_data_out(rd_data_out),
    .cmd_out(cmd_out),
    .len_out(len_out),
    .frame_valid_out(frame_valid_out),
    .frame_err_out(frame_err_out),
    .err_code_out(err_code_out),
    .busy_out(busy_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          v;
    logic          e;
    logic [1:0]    code;
    logic [7:0]    cmd;
    logic [LW-1:0] len;
  } exp_t;

  typedef struct {
    logic [7:0] sync;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] seed;
    logic [7:0] chk_xor;
    int         nsend;
    bit         rise_last;
    int         kind;
    logic [1:0] code;
  } vec_t;

  exp_t          sbq[$];
  logic [7:0]    m_cmd;
  logic [LW-1:0] m_len;
  logic [1:0]    m_code;
  vec_t          vecs[12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t x;
    if (frame_valid_out === 1'b1 || frame_err_out === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse valid=%0b err=%0b expected none",
                 frame_valid_out, frame_err_out);
      end else begin
        x = sbq.pop_front();
        check("pulse_valid", 32'(frame_valid_out), 32'(x.v));
        check("pulse_err", 32'(frame_err_out), 32'(x.e));
        if (x.e)
          check("err_code", 32'(err_code_out), 32'(x.code));
        check("cmd_at_pulse", 32'(cmd_out), 32'(x.cmd));
        check("len_at_pulse", 32'(len_out), 32'(x.len));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rise);
    byte_in = b;
    byte_valid_in = 1'b1;
    if (rise)
      sel_in = 1'b1;
    tick();
    byte_valid_in = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pulse pending=%0d expected 0",
               name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_cmd"}, 32'(cmd_out), 32'(m_cmd));
    check({name, "_len"}, 32'(len_out), 32'(m_len));
    check({name, "_code"}, 32'(err_code_out), 32'(m_code));
    check({name, "_busy"}, 32'(busy_out), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0] fb[$];
    logic [7:0] sum;
    logic [7:0] p;
    int nb;
    exp_t x;
    string nm;
    nm = $sformatf("vec%0d", id);
    fb.push_back(v.sync);
    fb.push_back(v.cmd);
    fb.push_back(v.len);
    sum = v.cmd + v.len;
    for (int i = 0; i < int'(v.len); i++) begin
      p = v.seed + 8'(i) * 8'h11;
      fb.push_back(p);
      sum = sum + p;
    end
    fb.push_back(sum ^ v.chk_xor);
    nb = (v.nsend == 0) ? fb.size() : v.nsend;
    if (v.kind == 1) begin
      x = '{1'b1, 1'b0, 2'd0, v.cmd, LW'(v.len)};
      sbq.push_back(x);
      m_cmd = v.cmd;
      m_len = LW'(v.len);
    end else if (v.kind == 2) begin
      x = '{1'b0, 1'b1, v.code, m_cmd, m_len};
      sbq.push_back(x);
      m_code = v.code;
    end
    sel_in = 1'b0;
    tick();
    for (int i = 0; i < nb; i++)
      send_byte(fb[i], v.rise_last && i == nb - 1);
    if (v.nsend != 0)
      check({nm, "_busy_mid"}, 32'(busy_out), 32'd1);
    sel_in = 1'b1;
    tick();
    if (v.nsend != 0)
      check({nm, "_busy_after_rise"}, 32'(busy_out), 32'd0);
    repeat (2) tick();
    wait_drain(nm);
    check_model(nm);
    if (v.kind == 1) begin
      for (int i = 0; i < int'(v.len); i++) begin
        rd_addr_in = AW'(i);
        tick();
        p = v.seed + 8'(i) * 8'h11;
        check($sformatf("%s_rd%0d", nm, i),
              32'(rd_data_out), 32'(p));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d expected finish", checks);
    $fatal(1);
  end

  initial begin
    // sync, cmd, len, seed, chk_xor, nsend, rise_last, kind, code
    vecs[0]  = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h00, 0, 1'b0, 1, 2'd0};
    vecs[1]  = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h89, 0, 1'b0, 2, 2'd3};
    vecs[2]  = '{8'h5A, 8'h11, 8'h22, 8'h00, 8'h00, 0, 1'b0, 2, 2'd1};
    vecs[3]  = '{8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1, 2'd0};
    vecs[4]  = '{8'hA5, 8'h01, 8'h11, 8'h00, 8'h00, 0, 1'b0, 2, 2'd2};
    vecs[5]  = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h00, 4, 1'b0, 2, 2'd0};
    vecs[6]  = '{8'hA5, 8'h3C, 8'h10, 8'h01, 8'h00, 0, 1'b0, 1, 2'd0};
    vecs[7]  = '{8'hA5, 8'h20, 8'h03, 8'hF0, 8'h00, 0, 1'b1, 1, 2'd0};
    vecs[8]  = '{8'hA5, 8'h20, 8'h03, 8'hF0, 8'h01, 0, 1'b1, 2, 2'd3};
    vecs[9]  = '{8'hA5, 8'h55, 8'h01, 8'h80, 8'h00, 4, 1'b0, 2, 2'd0};
    vecs[10] = '{8'hA5, 8'h66, 8'h01, 8'h80, 8'h00, 2, 1'b0, 2, 2'd0};
    vecs[11] = '{8'hA5, 8'h42, 8'h05, 8'h10, 8'h00, 0, 1'b0, 1, 2'd0};

    m_cmd = 8'd0;
    m_len = '0;
    m_code = 2'd0;
    rst_in = 1'b1;
    sel_in = 1'b1;
    byte_in = 8'd0;
    byte_valid_in = 1'b0;
    rd_addr_in = '0;
    repeat (3) tick();
    check("rst_valid", 32'(frame_valid_out), 32'd0);
    check("rst_err", 32'(frame_err_out), 32'd0);
    check("rst_rd_data", 32'(rd_data_out), 32'd0);
    check_model("rst");
    rst_in = 1'b0;
    repeat (2) tick();

    for (int k = 0; k < 12; k++)
      run_vec(vecs[k], k);

    // Reset in the middle of a payload: no pulses, reset values.
    sel_in = 1'b0;
    tick();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_in = 1'b1;
    tick();
    tick();
    m_cmd = 8'd0;
    m_len = '0;
    m_code = 2'd0;
    check("midrst_valid", 32'(frame_valid_out), 32'd0);
    check("midrst_err", 32'(frame_err_out), 32'd0);
    check("midrst_rd_data", 32'(rd_data_out), 32'd0);
    check_model("midrst");
    sel_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();

    // Bytes with select high and no falling edge are ignored.
    send_byte(8'hA5, 1'b0);
    check("idle_bytes_busy", 32'(busy_out), 32'd0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    repeat (4) tick();
    check_model("idle_bytes");

    run_vec(vecs[0], 12);

    repeat (4) tick();
    check("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
